sram_initiator: RTL and testbench

- Initiator side of the single-port SRAM interface (req/we/addr/wdata/be in, rdata out with fixed read latency).
- Accepts a valid/ready request stream from a client (cache, DMA) and issues at most one SRAM access per cycle.
- Tracks in-flight reads and returns read data on a valid/ready response stream, buffered in a credit-managed FIFO.
- Contains a clear engine that zero-fills the whole SRAM after reset or on command.

---
 rtl/sram_initiator.sv | 163 ++++++++++++++++
 tb/tb_sram_initiator.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_initiator.sv
// sram_initiator: single-port SRAM initiator with a zero-fill clear engine
// and a credit-managed, in-order read response FIFO.
module sram_initiator #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_WORDS     = 1024,
  parameter int READ_LATENCY  = 1,
  parameter int RSP_DEPTH     = 4,
  parameter bit INIT_ON_RESET = 1'b1,
  localparam int BW = (DATA_WIDTH + 7) / 8,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_i,
  output logic                  busy_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + READ_LATENCY + 1);
  localparam logic [AW-1:0] LAST = AW'(NUM_WORDS - 1);
  localparam logic [AW:0] NW = NUM_WORDS[AW:0];
  localparam logic [PW-1:0] PLAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(RSP_DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t state;
  logic [AW-1:0] cnt;

  logic [READ_LATENCY-1:0] pv;
  logic [READ_LATENCY-1:0] po;

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] used;

  logic oor;
  logic credit_ok;
  logic accept;
  logic rd_acc;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic [DATA_WIDTH-1:0] push_data;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + CW'(pv[i]);
  end

  // Credits cover both reads still in the SRAM pipe and queued responses
  assign used      = inflight + count;
  assign credit_ok = used < DEPTH;
  assign oor       = {1'b0, req_addr_i} >= NW;

  assign req_ready_o = rst_ni && (state == RUN) && !init_i
                       && (req_we_i || credit_ok);
  assign accept = req_valid_i && req_ready_o;
  assign rd_acc = accept && !req_we_i;
  assign busy_o = rst_ni && (state == CLEAR);

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
    if (rst_ni && state == CLEAR) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = cnt;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end else if (accept) begin
      sram_req_o = !oor;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= INIT_ON_RESET ? CLEAR : RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (init_i) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Out-of-range reads travel the pipe too so responses stay in order
  assign push      = pv[READ_LATENCY-1];
  assign push_data = po[READ_LATENCY-1] ? '0 : sram_rdata_i;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);

  assign rsp_valid_o = rst_ni && !empty;
  assign rsp_rdata_o = mem[rp];
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pv    <= '0;
      po    <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
      end
      pv[0] <= rd_acc;
      po[0] <= rd_acc && oor;
      if (push)
        wp <= (wp == PLAST) ? '0 : wp + 1'b1;
      if (pop)
        rp <= (rp == PLAST) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wp] <= push_data;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full && !pop));

endmodule

// File: tb/tb_sram_initiator.sv
// tb_sram_initiator: table vectors, directed corner sequences and random
// traffic checked against a transaction-level model of the initiator.
module tb_sram_initiator;

  localparam int DW = 64;
  localparam int NW = 12;
  localparam int RL = 2;
  localparam int RD = 4;
  localparam int AW = $clog2(NW);
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init;
  logic          busy;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic [DW-1:0] sram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_initiator #(
    .DATA_WIDTH(DW),
    .NUM_WORDS(NW),
    .READ_LATENCY(RL),
    .RSP_DEPTH(RD),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .init_i(init),
    .busy_o(busy),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .req_be_i(req_be),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req),
    .sram_we_o(sram_we),
    .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata)
  );

  // SRAM macro with fixed read latency, seeded with garbage
  logic [DW-1:0] macro [NW];
  logic [DW-1:0] rd_q [RL];
  bit seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < NW; i++) macro[i] <= {$urandom, $urandom};
      seeded <= 1'b1;
    end else if (sram_req && sram_we) begin
      for (int b = 0; b < BW; b++)
        if (sram_be[b]) macro[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
    rd_q[0] <= (sram_req && !sram_we) ? macro[sram_addr] : {$urandom, $urandom};
    for (int i = 1; i < RL; i++) rd_q[i] <= rd_q[i-1];
  end

  assign sram_rdata = rd_q[RL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory contents, expected response queue,
  // outstanding read count and clear progress.
  bit mvalid = 1'b0;
  bit mclear;
  int mcnt;
  int outst;
  bit mexp_rdy;
  bit macc;
  bit moor;
  bit mpop;
  logic [DW-1:0] mmem [NW];
  logic [DW-1:0] expq [$];

  initial forever begin
    @(negedge clk);
    mpop = 1'b0;
    if (!rst_n) begin
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_sram_req", 64'(sram_req), 64'd0);
      mvalid = 1'b1;
      mclear = 1'b1;
      mcnt = 0;
      outst = 0;
      expq.delete();
    end else if (mvalid) begin
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          chk("rsp_spurious", 64'(rsp_valid), 64'd0);
        end else begin
          chk("rsp_data", rsp_rdata, expq[0]);
          mpop = rsp_ready;
        end
      end
      if (mclear) begin
        chk("clr_busy", 64'(busy), 64'd1);
        chk("clr_ready", 64'(req_ready), 64'd0);
        chk("clr_sram_req", 64'(sram_req), 64'd1);
        chk("clr_we", 64'(sram_we), 64'd1);
        chk("clr_addr", 64'(sram_addr), 64'(mcnt));
        chk("clr_wdata", sram_wdata, 64'd0);
        chk("clr_be", 64'(sram_be), 64'hFF);
        mmem[mcnt] = '0;
        mcnt++;
        if (mcnt == NW) mclear = 1'b0;
      end else begin
        mexp_rdy = !init && (req_we || outst < RD);
        macc = req_valid && mexp_rdy;
        moor = int'(req_addr) >= NW;
        chk("run_busy", 64'(busy), 64'd0);
        chk("req_ready", 64'(req_ready), 64'(mexp_rdy));
        chk("sram_req", 64'(sram_req), 64'(macc && !moor));
        if (macc && !moor) begin
          chk("sram_we", 64'(sram_we), 64'(req_we));
          chk("sram_addr", 64'(sram_addr), 64'(req_addr));
          chk("sram_wdata", sram_wdata, req_wdata);
          chk("sram_be", 64'(sram_be), 64'(req_be));
          if (req_we)
            for (int b = 0; b < BW; b++)
              if (req_be[b]) mmem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end
        if (macc && !req_we) begin
          expq.push_back(moor ? '0 : mmem[req_addr]);
          outst++;
        end
        if (init) begin
          mclear = 1'b1;
          mcnt = 0;
        end
      end
      if (mpop) begin
        void'(expq.pop_front());
        outst--;
      end
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [9];
  vec_t v;
  int issue;
  int n;
  int acc;
  int got;
  int nb;
  bit ok;
  bit vh [16];
  logic [DW-1:0] dh [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t tv, output int iss);
    int k = 0;
    req_valid = 1'b1;
    req_we = tv.we;
    req_addr = tv.addr;
    req_wdata = tv.wdata;
    req_be = tv.be;
    forever begin
      @(negedge clk);
      k++;
      if (req_ready || k >= 50) break;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 64'(req_ready), 64'd1);
    iss = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    init = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    rsp_ready = 1'b1;

    tbl[0] = '{1'b0, 4'd5,  64'd0, 8'h00, 64'd0};
    tbl[1] = '{1'b1, 4'd3,  64'h1122334455667788, 8'hFF, 64'd0};
    tbl[2] = '{1'b1, 4'd3,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0};
    tbl[3] = '{1'b0, 4'd3,  64'd0, 8'h00, 64'h11223344AAAAAAAA};
    tbl[4] = '{1'b1, 4'd13, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'd0};
    tbl[5] = '{1'b0, 4'd13, 64'd0, 8'h00, 64'd0};
    tbl[6] = '{1'b1, 4'd7,  64'h0123456789ABCDEF, 8'hF0, 64'd0};
    tbl[7] = '{1'b0, 4'd7,  64'd0, 8'h00, 64'h0123456700000000};
    tbl[8] = '{1'b0, 4'd11, 64'd0, 8'h00, 64'd0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clear after reset lasts exactly NW cycles
    @(negedge clk);
    n = 0;
    while (busy && n < NW + 5) begin
      n++;
      @(negedge clk);
    end
    chk("clear_len", 64'(n), 64'(NW));
    tick();

    for (int i = 0; i < 9; i++) begin
      send(tbl[i], issue);
      if (!tbl[i].we) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rsp_valid && n < 20);
        chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'd1);
        chk($sformatf("tbl%0d_lat", i), 64'(cyc - issue), 64'(RL));
        chk($sformatf("tbl%0d_data", i), rsp_rdata, tbl[i].exp);
        tick();
      end
    end

    // Credit exhaustion with a stalled consumer
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      @(negedge clk);
      if (req_ready) acc++;
      tick();
    end
    chk("credit_accepts", 64'(acc), 64'(RD));
    req_we = 1'b1;
    req_addr = 4'd9;
    req_wdata = 64'h5555AAAA5555AAAA;
    req_be = 8'hFF;
    @(negedge clk);
    chk("credit_write_ok", 64'(req_ready), 64'd1);
    tick();
    req_we = 1'b0;
    req_addr = 4'd4;
    @(negedge clk);
    chk("credit_read_block", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ok = req_ready;
      tick();
    end while (!ok && n < 10);
    chk("credit_resume", 64'(ok), 64'd1);
    req_valid = 1'b0;
    repeat (10) tick();

    // Sustained back-to-back reads
    for (int i = 0; i < 8; i++) begin
      v = '{1'b1, AW'(i), 64'(i), 8'hFF, 64'd0};
      send(v, issue);
    end
    repeat (4) tick();
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) req_addr = AW'(i);
      else req_valid = 1'b0;
      @(negedge clk);
      if (i < 8) chk("tput_ready", 64'(req_ready), 64'd1);
      vh[i] = rsp_valid;
      dh[i] = rsp_rdata;
      tick();
    end
    chk("tput_no_early", 64'(vh[RL]), 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk("tput_valid", 64'(vh[RL+1+k]), 64'd1);
      chk("tput_data", dh[RL+1+k], 64'(k));
    end
    repeat (4) tick();

    // Reads in flight across an init pulse keep pre-clear data
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 4'd1;
    tick();
    req_addr = 4'd2;
    tick();
    req_valid = 1'b0;
    init = 1'b1;
    @(negedge clk);
    chk("init_busy_same", 64'(busy), 64'd0);
    tick();
    init = 1'b0;
    got = 0;
    nb = 0;
    for (int i = 0; i < NW + 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("init_busy_next", 64'(busy), 64'd1);
      if (busy) nb++;
      if (rsp_valid && got < 2) begin
        chk("preclear_rsp", rsp_rdata, 64'(got + 1));
        got++;
      end
    end
    chk("preclear_count", 64'(got), 64'd2);
    chk("reclear_len", 64'(nb), 64'(NW));
    tick();

    // Reset in the middle of a clear restarts it from word 0
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_addr", 64'(sram_addr), 64'd0);
    n = 0;
    while (busy && n < NW + 5) begin
      n++;
      @(negedge clk);
    end
    chk("rst_clear_len", 64'(n), 64'(NW));
    tick();

    // Random traffic, model checks every cycle
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we = 1'($urandom_range(0, 1));
      req_addr = AW'($urandom_range(0, 15));
      req_wdata = {$urandom, $urandom};
      req_be = BW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      init = ($urandom_range(0, 79) == 0);
      tick();
    end
    req_valid = 1'b0;
    init = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    chk("drain_empty", 64'(rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
